writeback_arbiter: RTL and testbench

Merges results from the single-cycle ALU and the multi-cycle memory unit into the register file's single write port (WriteData/WriteTarget/WriteEnable). The ALU normally has priority. Memory results are buffered in a small FIFO and protected from starvation. The block also forwards the in-flight write to the two operand read paths, covering the cycle before the register file holds the new value.

---
 rtl/writeback_arbiter_if.sv | 30 +++
 rtl/writeback_arbiter.sv | 74 +++++++
 tb/tb_writeback_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/memory result handshakes, register-file write port and operand bypass lanes.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_target;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_target;
  logic [31:0] mem_data;
  logic [31:0] write_data;
  logic [4:0]  write_target;
  logic        write_enable;
  logic [4:0]  read_src_a;
  logic [4:0]  read_src_b;
  logic        bypass_hit_a;
  logic        bypass_hit_b;
  logic [31:0] bypass_data_a;
  logic [31:0] bypass_data_b;
  modport slave (
    input  alu_valid, alu_target, alu_data, mem_valid, mem_target, mem_data, read_src_a, read_src_b,
    output alu_ready, mem_ready, write_data, write_target, write_enable,
           bypass_hit_a, bypass_hit_b, bypass_data_a, bypass_data_b
  );
  modport master (
    output alu_valid, alu_target, alu_data, mem_valid, mem_target, mem_data, read_src_a, read_src_b,
    input  alu_ready, mem_ready, write_data, write_target, write_enable,
           bypass_hit_a, bypass_hit_b, bypass_data_a, bypass_data_b
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and buffered memory results onto one register-file write port,
// with anti-starvation for memory results and forwarding of the in-flight write.
module writeback_arbiter #(
  parameter int FifoDepth   = 2,
  parameter int StarveLimit = 4
) (
  input logic clk,
  input logic rst_n,
  writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(FifoDepth);
  logic [36:0]   r_fifo [FifoDepth];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_starve;
  logic [4:0]    r_wt;
  logic [31:0]   r_wd;
  logic          r_we;
  logic          w_empty;
  logic          w_forced;
  logic          w_alu_win;
  logic          w_head_win;
  logic          w_push;
  logic [36:0]   w_head;
  logic [3:0]    w_starve_nxt;
  logic [AW:0]   w_count_nxt;
  logic [4:0]    w_wt_nxt;
  logic [31:0]   w_wd_nxt;
  logic          w_we_nxt;
  assign w_empty     = r_count == '0;
  assign w_forced    = !w_empty && r_starve == 4'(StarveLimit);
  assign w_alu_win   = bus.alu_valid && !w_forced;
  assign w_head_win  = !w_empty && !w_alu_win;
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_push      = bus.mem_valid && bus.mem_ready;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_head_win);
  // An ALU win over a non-empty FIFO implies r_starve < StarveLimit, so +1 saturates naturally.
  assign w_starve_nxt = (w_empty || w_head_win) ? 4'd0 : r_starve + 4'd1;
  assign bus.mem_ready = rst_n && r_count < (AW+1)'(FifoDepth);
  assign bus.alu_ready = rst_n && w_alu_win;
  always_comb begin
    w_wt_nxt = w_alu_win ? bus.alu_target : w_head_win ? w_head[36:32] : r_wt;
    w_wd_nxt = w_alu_win ? bus.alu_data : w_head_win ? w_head[31:0] : r_wd;
    w_we_nxt = (w_alu_win || w_head_win) && w_wt_nxt != 5'd0;
  end
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wr_ptr] <= {bus.mem_target, bus.mem_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_wt     <= '0;
      r_wd     <= '0;
      r_we     <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_wt     <= w_wt_nxt;
      r_wd     <= w_wd_nxt;
      r_we     <= w_we_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_head_win) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  assign bus.write_target  = r_wt;
  assign bus.write_data    = r_wd;
  assign bus.write_enable  = r_we;
  assign bus.bypass_hit_a  = r_we && r_wt == bus.read_src_a && bus.read_src_a != 5'd0;
  assign bus.bypass_hit_b  = r_we && r_wt == bus.read_src_b && bus.read_src_b != 5'd0;
  assign bus.bypass_data_a = r_wd;
  assign bus.bypass_data_b = r_wd;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed writeback arbitration scenarios with hand-computed expectations.
module tb_writeback_arbiter;
  logic clk;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  writeback_arbiter_if bus ();
  writeback_arbiter #(.FifoDepth(2), .StarveLimit(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd0;
    bus.alu_data = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_target = 5'd0;
    bus.mem_data = 32'd0;
    bus.read_src_a = 5'd0;
    bus.read_src_b = 5'd0;
    #12;
    chk("rst_we", bus.write_enable, 1'b0);
    chk("rst_wt", bus.write_target, 5'd0);
    chk("rst_wd", bus.write_data, 32'd0);
    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_mem_ready", bus.mem_ready, 1'b1);
    // ALU alone with forwarding
    bus.alu_target = 5'd5;
    bus.alu_data = 32'h12345678;
    bus.read_src_a = 5'd5;
    bus.read_src_b = 5'd6;
    #1;
    chk("alu_ready", bus.alu_ready, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    chk("alu_we", bus.write_enable, 1'b1);
    chk("alu_wt", bus.write_target, 5'd5);
    chk("alu_wd", bus.write_data, 32'h12345678);
    chk("alu_hit_a", bus.bypass_hit_a, 1'b1);
    chk("alu_bda", bus.bypass_data_a, 32'h12345678);
    chk("alu_hit_b", bus.bypass_hit_b, 1'b0);
    step();
    chk("idle_we", bus.write_enable, 1'b0);
    chk("idle_wt_hold", bus.write_target, 5'd5);
    // Memory alone: write two cycles after acceptance
    bus.mem_valid = 1'b1;
    bus.mem_target = 5'd7;
    bus.mem_data = 32'hDEADBEEF;
    #1;
    chk("mem_ready", bus.mem_ready, 1'b1);
    step();
    bus.mem_valid = 1'b0;
    chk("mem_we_n1", bus.write_enable, 1'b0);
    chk("mem_ready_n1", bus.mem_ready, 1'b1);
    step();
    chk("mem_we_n2", bus.write_enable, 1'b1);
    chk("mem_wt", bus.write_target, 5'd7);
    chk("mem_wd", bus.write_data, 32'hDEADBEEF);
    step();
    chk("mem_we_n3", bus.write_enable, 1'b0);
    // Starvation: four ALU wins, one forced memory write, ALU resumes
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd1;
    bus.alu_data = 32'h101;
    bus.mem_valid = 1'b1;
    bus.mem_target = 5'd9;
    bus.mem_data = 32'h909;
    bus.read_src_b = 5'd9;
    #1;
    chk("st_ready0", bus.alu_ready, 1'b1);
    step();
    bus.mem_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      bus.alu_target = 5'(i);
      bus.alu_data = 32'(32'h100 + i);
      #1;
      chk("st_ready", bus.alu_ready, 1'b1);
      chk("st_wt", bus.write_target, 37'(i - 1));
      step();
    end
    bus.alu_target = 5'd6;
    bus.alu_data = 32'h106;
    #1;
    chk("st_forced", bus.alu_ready, 1'b0);
    chk("st_wt5", bus.write_target, 5'd5);
    step();
    chk("st_mem_wt", bus.write_target, 5'd9);
    chk("st_mem_wd", bus.write_data, 32'h909);
    chk("st_mem_we", bus.write_enable, 1'b1);
    chk("st_hit_b", bus.bypass_hit_b, 1'b1);
    chk("st_resume", bus.alu_ready, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    chk("st_held_wt", bus.write_target, 5'd6);
    chk("st_held_wd", bus.write_data, 32'h106);
    // FIFO full with the ALU busy
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd10;
    bus.alu_data = 32'h20A;
    bus.mem_valid = 1'b1;
    bus.mem_target = 5'd20;
    bus.mem_data = 32'h314;
    #1;
    chk("ff_ready0", bus.mem_ready, 1'b1);
    step();
    bus.alu_target = 5'd11;
    bus.alu_data = 32'h20B;
    bus.mem_target = 5'd21;
    bus.mem_data = 32'h315;
    #1;
    chk("ff_ready1", bus.mem_ready, 1'b1);
    chk("ff_alu1", bus.alu_ready, 1'b1);
    step();
    bus.alu_target = 5'd12;
    bus.alu_data = 32'h20C;
    bus.mem_target = 5'd22;
    bus.mem_data = 32'h316;
    #1;
    chk("ff_full", bus.mem_ready, 1'b0);
    step();
    bus.alu_target = 5'd13;
    bus.alu_data = 32'h20D;
    step();
    bus.alu_target = 5'd14;
    bus.alu_data = 32'h20E;
    step();
    bus.alu_target = 5'd15;
    bus.alu_data = 32'h20F;
    #1;
    chk("ff_forced", bus.alu_ready, 1'b0);
    chk("ff_full2", bus.mem_ready, 1'b0);
    chk("ff_wt14", bus.write_target, 5'd14);
    step();
    chk("ff_wt20", bus.write_target, 5'd20);
    chk("ff_wd20", bus.write_data, 32'h314);
    chk("ff_ready_pop", bus.mem_ready, 1'b1);
    chk("ff_alu_back", bus.alu_ready, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    chk("ff_wt15", bus.write_target, 5'd15);
    step();
    chk("ff_wt21", bus.write_target, 5'd21);
    step();
    chk("ff_wt22", bus.write_target, 5'd22);
    chk("ff_wd22", bus.write_data, 32'h316);
    step();
    chk("ff_drained", bus.write_enable, 1'b0);
    // r0 writes are consumed silently
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd0;
    bus.alu_data = 32'hFFFFFFFF;
    bus.read_src_a = 5'd0;
    #1;
    chk("r0_ready", bus.alu_ready, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    chk("r0_we", bus.write_enable, 1'b0);
    chk("r0_hit_a", bus.bypass_hit_a, 1'b0);
    chk("r0_bda", bus.bypass_data_a, 32'hFFFFFFFF);
    // Asynchronous reset mid-operation
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd3;
    bus.alu_data = 32'h403;
    bus.mem_valid = 1'b1;
    bus.mem_target = 5'd25;
    bus.mem_data = 32'h525;
    step();
    bus.alu_target = 5'd4;
    bus.alu_data = 32'h404;
    bus.mem_target = 5'd26;
    bus.mem_data = 32'h526;
    bus.read_src_a = 5'd4;
    step();
    chk("pre_rst_we", bus.write_enable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bus.write_enable, 1'b0);
    chk("mid_rst_wt", bus.write_target, 5'd0);
    chk("mid_rst_wd", bus.write_data, 32'd0);
    chk("mid_rst_mem_ready", bus.mem_ready, 1'b0);
    chk("mid_rst_alu_ready", bus.alu_ready, 1'b0);
    chk("mid_rst_hit_a", bus.bypass_hit_a, 1'b0);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_mem_ready", bus.mem_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale_we", bus.write_enable, 1'b0);
    end
    bus.alu_valid = 1'b1;
    bus.alu_target = 5'd8;
    bus.alu_data = 32'h808;
    step();
    bus.alu_valid = 1'b0;
    chk("post_rst_we", bus.write_enable, 1'b1);
    chk("post_rst_wt", bus.write_target, 5'd8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
